muldiv_scheduler: RTL and testbench

Multi-cycle multiply/divide controller for the execute stage of the dual-issue pipeline. It arbitrates between the two issue slots competing for one shared MULT/MULTU/DIV/DIVU resource, sequences a fixed-latency multiply or a 32-step iterative divide, and returns a 64-bit {hi, lo} result with a one-cycle done strobe. The pipeline stalls on `busy` and writes HI/LO on `done_valid`.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/div_iter.sv | 59 +++++
 rtl/muldiv_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_muldiv_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    localparam int         DIV_STEPS     = 32;
    localparam logic [4:0] DIV_LAST_STEP = 5'(DIV_STEPS - 1);

    // Divide ops share the upper opcode bit.
    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Absolute value when the operand is treated as signed, raw value otherwise.
    // The most negative value maps onto 32'h8000_0000, which is correct as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        logic [31:0] m;
        if (is_signed && v[31]) begin
            m = 32'd0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// Sequencing (start/step) and sign handling belong to the scheduler.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic [32:0] shifted_s;
    logic        fits_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;

    // One trial subtraction: shift the next dividend bit into the partial remainder.
    always_comb begin
        shifted_s  = {rem_r, quo_r[31]};
        fits_s     = (shifted_s >= {1'b0, dvs_r});
        quo_next_s = {quo_r[30:0], fits_s};
        if (fits_s) begin
            // Result is below the divisor, so the low 32 bits of the difference are exact.
            rem_next_s = shifted_s[31:0] - dvs_r;
        end else begin
            rem_next_s = shifted_s[31:0];
        end
    end

    // Remainder/quotient shift registers; start loads operands, step advances one bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dvs_r <= 32'd0;
        end else if (start) begin
            rem_r <= 32'd0;
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (step) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end else begin
            rem_r <= rem_r;
            quo_r <= quo_r;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_scheduler.sv
// Shared MULT/MULTU/DIV/DIVU unit for the two issue slots: arbitration,
// fixed-latency multiply, 32-step divide, and a one-cycle done strobe.
module muldiv_scheduler
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done_valid,
    output logic        done_slot,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // MUL state is held MUL_LAT-1 cycles: counter runs MUL_LAT-2 down to 0.
    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 2);

    muldiv_state_t state_r, state_next_s;
    muldiv_op_t    op_r, sel_op_s;
    logic [31:0]   a_r, b_r, sel_a_s, sel_b_s;
    logic          slot_r, sel_slot_s, accept_s;
    logic [4:0]    cnt_r;
    logic [31:0]   hi_r, lo_r, res_hi_s, res_lo_s;
    logic          div_start_s, div_step_s;
    logic [31:0]   div_quo_s, div_rem_s;
    logic [63:0]   ext_a_s, ext_b_s, product_s;
    logic [31:0]   quo_fix_s, rem_fix_s;

    // Arbitration: only IDLE accepts, slot 0 (older) has priority, flush blocks accept.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept_s   = 1'b0;
        sel_slot_s = 1'b0;
        sel_op_s   = muldiv_op_t'(req0_op);
        sel_a_s    = req0_a;
        sel_b_s    = req0_b;
        if ((state_r == ST_IDLE) && !flush && !reset) begin
            req0_ready = 1'b1;
            req1_ready = !req0_valid;
            if (req0_valid) begin
                accept_s = 1'b1;
            end else if (req1_valid) begin
                accept_s   = 1'b1;
                sel_slot_s = 1'b1;
                sel_op_s   = muldiv_op_t'(req1_op);
                sel_a_s    = req1_a;
                sel_b_s    = req1_b;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state and status outputs of the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        busy         = 1'b1;
        done_valid   = 1'b0;
        div_step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept_s) begin
                    state_next_s = is_div_op(sel_op_s) ? ST_DIV : ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == 5'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    div_step_s = 1'b1;
                    if (cnt_r == DIV_LAST_STEP) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end
            end
            ST_DONE: begin
                done_valid   = !flush;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the accepted request so operands stay stable while the unit works.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r   <= OP_MULT;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            slot_r <= 1'b0;
        end else if (accept_s) begin
            op_r   <= sel_op_s;
            a_r    <= sel_a_s;
            b_r    <= sel_b_s;
            slot_r <= sel_slot_s;
        end else begin
            op_r   <= op_r;
            a_r    <= a_r;
            b_r    <= b_r;
            slot_r <= slot_r;
        end
    end

    // Shared counter: multiply delay count-down, or divide step number 0..31.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 5'd0;
        end else if (accept_s) begin
            cnt_r <= is_div_op(sel_op_s) ? 5'd0 : MUL_LOAD;
        end else if ((state_r == ST_MUL) && !flush && (cnt_r != 5'd0)) begin
            cnt_r <= cnt_r - 5'd1;
        end else if (div_step_s) begin
            cnt_r <= cnt_r + 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign div_start_s = accept_s && is_div_op(sel_op_s);

    div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .step      (div_step_s),
        .dividend  (magnitude(sel_a_s, sel_op_s == OP_DIV)),
        .divisor   (magnitude(sel_b_s, sel_op_s == OP_DIV)),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Final result: product for multiplies, sign-corrected quotient/remainder for divides.
    always_comb begin
        ext_a_s   = (op_r == OP_MULT) ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        ext_b_s   = (op_r == OP_MULT) ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        product_s = ext_a_s * ext_b_s;
        quo_fix_s = div_quo_s;
        rem_fix_s = div_rem_s;
        res_hi_s  = product_s[63:32];
        res_lo_s  = product_s[31:0];
        if (op_r == OP_DIV) begin
            // Truncate toward zero: quotient sign from operand signs, remainder follows dividend.
            if (a_r[31] ^ b_r[31]) begin
                quo_fix_s = 32'd0 - div_quo_s;
            end else begin
                quo_fix_s = div_quo_s;
            end
            if (a_r[31]) begin
                rem_fix_s = 32'd0 - div_rem_s;
            end else begin
                rem_fix_s = div_rem_s;
            end
        end else begin
            quo_fix_s = div_quo_s;
            rem_fix_s = div_rem_s;
        end
        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_hi_s = product_s[63:32];
                res_lo_s = product_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b_r == 32'd0) begin
                    // Divide by zero is not trapped: all-ones quotient, raw dividend as remainder.
                    res_hi_s = a_r;
                    res_lo_s = 32'hFFFF_FFFF;
                end else begin
                    res_hi_s = rem_fix_s;
                    res_lo_s = quo_fix_s;
                end
            end
            default: begin
                res_hi_s = product_s[63:32];
                res_lo_s = product_s[31:0];
            end
        endcase
    end

    // HI/LO commit on the edge leaving DONE; a flush in DONE discards the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if ((state_r == ST_DONE) && !flush) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign hi        = hi_r;
    assign lo        = lo_r;
    assign done_slot = slot_r;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Self-checking bench for muldiv_scheduler: directed cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_scheduler;

    localparam int LAT     = 4;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        flush;
    logic        busy, done_valid, done_slot;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_scheduler #(.MUL_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .flush      (flush),
        .busy       (busy),
        .done_valid (done_valid),
        .done_slot  (done_slot),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin q = sa * sb; return q; end
            2'b01: begin p = ua * ub; return p; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                q = longint'(ua % ub);
                return {q[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Present one request in an IDLE cycle, confirm it is taken, then drop valid.
    task automatic accept(input logic slot, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        if (slot == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        check({tag, "_ready"}, {63'd0, (slot ? req1_ready : req0_ready)}, 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Called in C1: wait for the strobe, check latency/slot, then the committed result.
    task automatic finish_op(input logic slot, input logic [63:0] exp, input int lat, input string tag);
        int n = 1;
        while (done_valid !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_slot"}, {63'd0, done_slot}, {63'd0, slot});
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        tick();
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_idle"}, {62'd0, busy, done_valid}, 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        slot;
        int          n;
        int          ready1_seen;

        reset = 1'b1; flush = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0;
        tick();
        tick();
        check("reset_status", {60'd0, busy, done_valid, done_slot, req0_ready}, 64'd0);
        check("reset_ready1", {63'd0, req1_ready}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2 reset = 1'b0;
        tick();

        // Signed multiply, slot 0.
        accept(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg");
        finish_op(1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, LAT, "mult_neg");

        // Unsigned divide, slot 1.
        accept(1'b1, 2'b11, 32'd100, 32'd7, "divu");
        finish_op(1'b1, {32'd2, 32'd14}, DIV_LAT, "divu");

        // Signed divide, truncation toward zero.
        accept(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        finish_op(1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT, "div_neg");

        // Simultaneous requests: slot 0 wins, slot 1 waits for IDLE.
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'd2; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'd9; req1_b = 32'd4;
        #1;
        check("arb_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
        tick();
        req0_valid = 1'b0;
        n = 1;
        ready1_seen = 0;
        while (done_valid !== 1'b1 && n < 80) begin
            if (req1_ready) ready1_seen++;
            tick();
            n++;
        end
        if (req1_ready) ready1_seen++;
        check("arb_mul_latency", 64'(n), 64'(LAT));
        check("arb_req1_held", 64'(ready1_seen), 64'd0);
        check("arb_mul_slot", {63'd0, done_slot}, 64'd0);
        tick();
        check("arb_mul_hilo", {hi, lo}, {32'd0, 32'd6});
        check("arb_req1_ready_idle", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        finish_op(1'b1, {32'd1, 32'd2}, DIV_LAT, "arb_divu");

        // Divide by zero: no trap, no hang.
        accept(1'b0, 2'b10, 32'd123, 32'd0, "div0");
        finish_op(1'b0, {32'd123, 32'hFFFF_FFFF}, DIV_LAT, "div0");

        // Flush in cycle C10 of a divide.
        accept(1'b0, 2'b11, 32'd5000, 32'd3, "flush_div");
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush_div_no_done", {63'd0, done_valid}, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_div_idle", {63'd0, busy}, 64'd0);
        check("flush_div_hilo_kept", {hi, lo}, {32'd123, 32'hFFFF_FFFF});
        accept(1'b1, 2'b01, 32'd7, 32'd6, "after_flush");
        finish_op(1'b1, {32'd0, 32'd42}, LAT, "after_flush");

        // Flush during the DONE cycle discards the result.
        accept(1'b0, 2'b00, 32'd3, 32'd3, "flush_done");
        repeat (LAT - 1) tick();
        check("flush_done_strobe", {63'd0, done_valid}, 64'd1);
        flush = 1'b1;
        #1;
        check("flush_done_masked", {63'd0, done_valid}, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_done_hilo_kept", {hi, lo}, {32'd0, 32'd42});
        check("flush_done_idle", {63'd0, busy}, 64'd0);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        check("flush_idle_ready", {63'd0, req0_ready}, 64'd0);
        tick();
        check("flush_idle_no_accept", {63'd0, busy}, 64'd0);
        flush = 1'b0; req0_valid = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        accept(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst_mid");
        #2 reset = 1'b1;
        #1;
        check("rst_mid_status", {62'd0, busy, done_valid}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        accept(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "after_rst");
        finish_op(1'b1, model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), LAT, "after_rst");

        // Random back-to-back traffic against the reference model.
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 3));
            slot = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            accept(slot, op, a, b, "rand");
            finish_op(slot, model(op, a, b), (op[1] ? DIV_LAT : LAT), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
